writeback_queue: RTL and testbench
==================================

# writeback_queue

Write-port front end for the 16-entry, 16-bit register file. It merges the single-cycle ALU/result path with a decoupled long-latency source, such as a load unit or iterative multiplier, into the register file's single write port (DstReg/WriteReg/DstData). Long-latency results are buffered in a small FIFO and drained whenever the single-cycle path does not need the port. A pending-write scoreboard lets hazard logic stall reads of registers that still have buffered writes.

## Interface
- DEPTH, 4, FIFO entries; power of two, 2..16
- DW, 16, data width; must match the register file
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-low
- alu_we  in  1  single-cycle path write request this cycle
- alu_reg  in  4  single-cycle destination register
- alu_data  in  DW  single-cycle write data
- lq_valid  in  1  long-latency result valid
- lq_ready  out  1  queue can accept; lq_valid && lq_ready = push
- lq_reg  in  4  long-latency destination register
- lq_data  in  DW  long-latency write data
- SrcReg1, SrcReg2  in  4  registers being read this cycle
- hazard1, hazard2  out  1  buffered write to SrcReg1 / SrcReg2 outstanding
- pending  out  16  bit r = some live entry targets register r
- DstReg  out  4  register file write address
- WriteReg  out  1  register file write enable
- DstData  out  DW  register file write data

## Operation
- FIFO entries hold {reg, data, live}; head/tail pointers wrap modulo DEPTH; count is clog2(DEPTH)+1 bits.
- Write-port priority, combinational:
  1. alu_we=1: the port carries alu_reg/alu_data and WriteReg=1.
  2. Otherwise, if the head entry is live: the port carries the head entry, WriteReg=1, and the entry is popped.
  3. Otherwise WriteReg=0; DstReg/DstData are don't-care, driven with the head entry.
- A dead head entry is popped without writing, regardless of alu_we.
- Ordering/kill rule: an alu_we to register R clears `live` on every stored entry whose reg==R. The newer single-cycle result must not be overwritten by an older buffered one.
- A push in the same cycle as an ALU write to the same register is younger: it is stored live and not killed.
- lq_ready = (count < DEPTH), from registered state only. There is no push-when-full even if a pop occurs that cycle.
- Simultaneous push and pop: count unchanged, both pointers advance.
- pending = OR over live entries of onehot(reg). hazard1 = pending[SrcReg1]; hazard2 = pending[SrcReg2]. All are combinational from registered state.
- Reset while rst=0: FIFO emptied, all live bits 0, pointers 0, pending=0, hazard1/2=0.
  - lq_ready forced 0.
  - WriteReg forced 0 (ALU writes suppressed).
- Reset asserted mid-drain discards all buffered entries; no partial write is issued.

## Timing
- ALU path: 0-cycle latency. The register file captures at the edge ending the cycle in which alu_we=1.
- Long-latency path with the macro absent: push accepted at edge N. Entry earliest on the port in cycle N→N+1, written at edge N+1. pending/hazard reflect the entry from edge N until the edge it is written or killed.
- Drain rate: one entry per cycle while alu_we=0.
- After rst deasserts, lq_ready=1 in the same cycle, from the empty FIFO.

## Configuration
- WBQ_BYPASS_EN defined:
  - If the FIFO is empty, alu_we=0 and lq_valid=1, the incoming result drives the port in the same cycle (WriteReg=1) and is not stored.
  - Such a bypassed write never appears in pending.
  - lq_ready is unchanged, so the handshake is still required.
- WBQ_BYPASS_EN undefined: every long-latency result passes through the FIFO, with minimum latency as given under Timing.

## Test plan
- Reset: hold rst=0 with alu_we=1, lq_valid=1 -> WriteReg=0, lq_ready=0, pending=0. Release -> lq_ready=1.
- Basic drain: push (R3,0x1234) -> pending=0x0008, hazard1=1 with SrcReg1=3. Next cycle WriteReg=1, DstReg=3, DstData=0x1234. After that edge, pending=0. (Without WBQ_BYPASS_EN.)
- Full/stall: DEPTH=4, alu_we held 1 and five pushes -> the first four are accepted, lq_ready=0 on the fifth. Drop alu_we -> four consecutive writes in FIFO order, then lq_ready returns to 1.
- Kill: push (R5,0xAAAA), then alu_we to R5 with 0xBBBB before drain -> RF R5 ends 0xBBBB. The dead entry pops with WriteReg=0, and pending[5] clears at the kill edge.
- Same-cycle younger push: alu_we (R7,0x0001) and push (R7,0x0002) in one cycle -> the next cycle writes R7=0x0002, and pending[7]=1 until then.
- Bypass (WBQ_BYPASS_EN): empty FIFO, push (R2,0x00FF) with alu_we=0 -> WriteReg=1, DstReg=2 in the same cycle, pending stays 0.

Source files
------------

// File: rtl/writeback_queue.sv
// writeback_queue: register-file write-port arbiter with long-latency FIFO.
// Optional macro WBQ_BYPASS_EN: empty-FIFO results drive the port directly.
module writeback_queue #(
   parameter int DEPTH = 4,
   parameter int DW    = 16
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          alu_we,
   input  logic [3:0]    alu_reg,
   input  logic [DW-1:0] alu_data,
   input  logic          lq_valid,
   output logic          lq_ready,
   input  logic [3:0]    lq_reg,
   input  logic [DW-1:0] lq_data,
   input  logic [3:0]    SrcReg1,
   input  logic [3:0]    SrcReg2,
   output logic          hazard1,
   output logic          hazard2,
   output logic [15:0]   pending,
   output logic [3:0]    DstReg,
   output logic          WriteReg,
   output logic [DW-1:0] DstData
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [3:0]       reg_q  [DEPTH];
   logic [DW-1:0]    data_q [DEPTH];
   logic [DEPTH-1:0] live_q;
   logic [AW-1:0]    head_q;
   logic [AW-1:0]    tail_q;
   logic [CW-1:0]    count_q;

   logic empty;
   logic head_live;
   logic push;
   logic store;
   logic pop;
   logic byp;

   assign empty     = (count_q == '0);
   assign head_live = live_q[head_q];
   assign lq_ready  = rst && (count_q < CW'(DEPTH));
   assign push      = lq_valid && lq_ready;

`ifdef WBQ_BYPASS_EN
   assign byp = empty && !alu_we && push;
`else
   assign byp = 1'b0;
`endif

   assign store = push && !byp;
   // Dead heads retire silently; live heads only when the ALU is idle.
   assign pop   = !empty && (!head_live || !alu_we);

   // Write-port mux: ALU first, then bypass, then live FIFO head.
   always_comb begin
      WriteReg = 1'b0;
      DstReg   = reg_q[head_q];
      DstData  = data_q[head_q];
      if (alu_we) begin
         WriteReg = 1'b1;
         DstReg   = alu_reg;
         DstData  = alu_data;
      end else if (byp) begin
         WriteReg = 1'b1;
         DstReg   = lq_reg;
         DstData  = lq_data;
      end else if (head_live) begin
         WriteReg = 1'b1;
      end
      if (!rst) begin
         WriteReg = 1'b0;
      end
   end

   // Scoreboard of registers with a live buffered write.
   always_comb begin
      pending = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (live_q[i]) begin
            pending[reg_q[i]] = 1'b1;
         end
      end
   end

   assign hazard1 = pending[SrcReg1];
   assign hazard2 = pending[SrcReg2];

   // FIFO state: kill older entries on ALU write, then pop and push.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         live_q  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            reg_q[i]  <= '0;
            data_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (alu_we && reg_q[i] == alu_reg) begin
               live_q[i] <= 1'b0;
            end
         end
         if (pop) begin
            live_q[head_q] <= 1'b0;
            head_q         <= head_q + 1'b1;
         end
         if (store) begin
            reg_q[tail_q]  <= lq_reg;
            data_q[tail_q] <= lq_data;
            live_q[tail_q] <= 1'b1;
            tail_q         <= tail_q + 1'b1;
         end
         count_q <= count_q + CW'(store) - CW'(pop);
      end
   end

endmodule

// File: tb/tb_writeback_queue.sv
// tb_writeback_queue: directed stimulus, expected writes queued in order.
// A negedge monitor pops the queue on every register-file write.
module tb_writeback_queue;

   logic        clk = 1'b0;
   logic        rst;
   logic        alu_we;
   logic [3:0]  alu_reg;
   logic [15:0] alu_data;
   logic        lq_valid;
   logic        lq_ready;
   logic [3:0]  lq_reg;
   logic [15:0] lq_data;
   logic [3:0]  SrcReg1;
   logic [3:0]  SrcReg2;
   logic        hazard1;
   logic        hazard2;
   logic [15:0] pending;
   logic [3:0]  DstReg;
   logic        WriteReg;
   logic [15:0] DstData;

   int total = 0;
   int bad   = 0;
   logic [19:0] exp_q[$];
   logic [15:0] rf [16];

   writeback_queue #(.DEPTH(4), .DW(16)) dut (
      .clk(clk), .rst(rst),
      .alu_we(alu_we), .alu_reg(alu_reg), .alu_data(alu_data),
      .lq_valid(lq_valid), .lq_ready(lq_ready),
      .lq_reg(lq_reg), .lq_data(lq_data),
      .SrcReg1(SrcReg1), .SrcReg2(SrcReg2),
      .hazard1(hazard1), .hazard2(hazard2), .pending(pending),
      .DstReg(DstReg), .WriteReg(WriteReg), .DstData(DstData)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic we, input logic [3:0] ar,
                        input logic [15:0] ad, input logic lv,
                        input logic [3:0] lr, input logic [15:0] ld);
      alu_we   = we;
      alu_reg  = ar;
      alu_data = ad;
      lq_valid = lv;
      lq_reg   = lr;
      lq_data  = ld;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_wr(input logic [3:0] r, input logic [15:0] d);
      exp_q.push_back({r, d});
   endtask

   // Monitor: every observed write must match the next expected one.
   always @(negedge clk) begin
      if (WriteReg) begin
         rf[DstReg] = DstData;
         if (!rst) begin
            chk("write_in_reset", 32'(WriteReg), 32'd0);
         end else if (exp_q.size() == 0) begin
            chk("unexpected_write", {12'd0, DstReg, DstData}, 32'hFFFF_FFFF);
         end else begin
            logic [19:0] e;
            e = exp_q.pop_front();
            chk("port_write", {12'd0, DstReg, DstData}, {12'd0, e});
         end
      end
   end

   initial begin
      for (int i = 0; i < 16; i++) rf[i] = 16'h0;
      rst     = 1'b0;
      SrcReg1 = 4'd3;
      SrcReg2 = 4'd4;
      drive(1'b1, 4'd1, 16'hDEAD, 1'b1, 4'd2, 16'hBEEF);

      // reset holds the port and handshake off
      @(negedge clk);
      chk("rst_wr", 32'(WriteReg), 32'd0);
      chk("rst_rdy", 32'(lq_ready), 32'd0);
      chk("rst_pend", 32'(pending), 32'd0);
      chk("rst_haz1", 32'(hazard1), 32'd0);
      tick();
      @(negedge clk);
      chk("rst_wr2", 32'(WriteReg), 32'd0);
      tick();
      rst = 1'b1;
      drive(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0);
      @(negedge clk);
      chk("rel_rdy", 32'(lq_ready), 32'd1);
      chk("rel_pend", 32'(pending), 32'd0);
      tick();

`ifndef WBQ_BYPASS_EN
      // basic drain through the FIFO
      drive(1'b0, 4'd0, 16'h0, 1'b1, 4'd3, 16'h1234);
      expect_wr(4'd3, 16'h1234);
      @(negedge clk);
      chk("drain_pend0", 32'(pending), 32'd0);
      tick();
      drive(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0);
      @(negedge clk);
      chk("drain_pend", 32'(pending), 32'h0008);
      chk("drain_haz1", 32'(hazard1), 32'd1);
      chk("drain_haz2", 32'(hazard2), 32'd0);
      chk("drain_wr", 32'(WriteReg), 32'd1);
      tick();
      @(negedge clk);
      chk("drain_pend_clr", 32'(pending), 32'd0);
      chk("drain_haz_clr", 32'(hazard1), 32'd0);
      tick();
`else
      // bypass: empty FIFO, idle ALU -> same-cycle write, never pending
      drive(1'b0, 4'd0, 16'h0, 1'b1, 4'd2, 16'h00FF);
      expect_wr(4'd2, 16'h00FF);
      @(negedge clk);
      chk("byp_wr", 32'(WriteReg), 32'd1);
      chk("byp_reg", 32'(DstReg), 32'd2);
      chk("byp_pend", 32'(pending), 32'd0);
      chk("byp_rdy", 32'(lq_ready), 32'd1);
      tick();
      drive(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0);
      @(negedge clk);
      chk("byp_pend2", 32'(pending), 32'd0);
      chk("byp_idle", 32'(WriteReg), 32'd0);
      tick();
`endif

      // full/stall: ALU holds the port, five push attempts
      for (int k = 0; k < 5; k++) begin
         drive(1'b1, 4'd15, 16'hF000 + 16'(k), 1'b1, 4'(8 + k),
               16'h1000 + 16'(k));
         expect_wr(4'd15, 16'hF000 + 16'(k));
         @(negedge clk);
         chk("full_rdy", 32'(lq_ready), (k < 4) ? 32'd1 : 32'd0);
         tick();
      end
      drive(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0);
      for (int k = 0; k < 4; k++) expect_wr(4'(8 + k), 16'h1000 + 16'(k));
      @(negedge clk);
      chk("full_pend", 32'(pending), 32'h0F00);
      chk("full_rdy0", 32'(lq_ready), 32'd0);
      for (int k = 0; k < 4; k++) begin
         if (k > 0) @(negedge clk);
         chk("full_drain_wr", 32'(WriteReg), 32'd1);
         tick();
      end
      @(negedge clk);
      chk("full_rdy_back", 32'(lq_ready), 32'd1);
      chk("full_pend_clr", 32'(pending), 32'd0);
      chk("full_idle", 32'(WriteReg), 32'd0);
      tick();

      // kill: buffered R5 overwritten by a newer ALU write
      drive(1'b1, 4'd0, 16'h0C0C, 1'b1, 4'd5, 16'hAAAA);
      expect_wr(4'd0, 16'h0C0C);
      tick();
      drive(1'b1, 4'd5, 16'hBBBB, 1'b0, 4'd0, 16'h0);
      expect_wr(4'd5, 16'hBBBB);
      @(negedge clk);
      chk("kill_pend", 32'(pending), 32'h0020);
      tick();
      drive(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0);
      @(negedge clk);
      chk("kill_pend_clr", 32'(pending), 32'd0);
      chk("kill_dead_pop", 32'(WriteReg), 32'd0);
      tick();
      @(negedge clk);
      chk("kill_idle", 32'(WriteReg), 32'd0);
      chk("kill_rf5", 32'(rf[5]), 32'h0000_BBBB);
      tick();

      // same-cycle push to the ALU's register is younger and survives
      SrcReg2 = 4'd7;
      drive(1'b1, 4'd7, 16'h0001, 1'b1, 4'd7, 16'h0002);
      expect_wr(4'd7, 16'h0001);
      tick();
      drive(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0);
      expect_wr(4'd7, 16'h0002);
      @(negedge clk);
      chk("young_pend", 32'(pending), 32'h0080);
      chk("young_haz2", 32'(hazard2), 32'd1);
      tick();
      @(negedge clk);
      chk("young_pend_clr", 32'(pending), 32'd0);
      chk("young_rf7", 32'(rf[7]), 32'h0000_0002);
      tick();

      // reset mid-drain discards buffered entries
      drive(1'b1, 4'd1, 16'h1111, 1'b1, 4'd4, 16'h4444);
      expect_wr(4'd1, 16'h1111);
      tick();
      drive(1'b1, 4'd1, 16'h2222, 1'b1, 4'd6, 16'h6666);
      expect_wr(4'd1, 16'h2222);
      @(negedge clk);
      chk("mid_pend", 32'(pending), 32'h0010);
      tick();
      rst = 1'b0;
      drive(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0);
      @(negedge clk);
      chk("mid_rst_wr", 32'(WriteReg), 32'd0);
      chk("mid_rst_pend", 32'(pending), 32'd0);
      tick();
      rst = 1'b1;
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         chk("mid_after_wr", 32'(WriteReg), 32'd0);
         chk("mid_after_pend", 32'(pending), 32'd0);
         tick();
      end

      chk("sb_empty", 32'(exp_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
